// File: rtl/dec_pkg.sv
// Shared types and helpers for the decoder request encoder.
package dec_pkg;

  localparam int N_REQ = 16;
  localparam int IDX_W = 4;

  typedef enum logic [1:0] {
    MODE_2X4  = 2'b00,
    MODE_3X8  = 2'b01,
    MODE_4X16 = 2'b10
  } dec_mode_t;

  // Narrowest decoder mode that can address the given index.
  function automatic dec_mode_t idx_to_mode(input logic [IDX_W-1:0] idx);
    if (idx[3]) return MODE_4X16;
    if (idx[2]) return MODE_3X8;
    return MODE_2X4;
  endfunction

endpackage

// File: rtl/dec_req_pick.sv
// Combinational picker: chooses one candidate request.
// Default build selects the highest set index.
// With DEC_REQ_ROUND_ROBIN_EN defined it selects the first set bit searching
// upward from rotation pointer p, wrapping at N_REQ.
module dec_req_pick
  import dec_pkg::*;
(
  input  logic [N_REQ-1:0] cand,
`ifdef DEC_REQ_ROUND_ROBIN_EN
  input  logic [IDX_W-1:0] p,
`endif
  output logic             found,
  output logic [IDX_W-1:0] idx
);

`ifdef DEC_REQ_ROUND_ROBIN_EN
  logic [IDX_W-1:0] j;

  // Scan offsets from far to near so the bit closest above p is kept last.
  always_comb begin
    found = |cand;
    idx   = '0;
    j     = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      j = p + IDX_W'(i);
      if (cand[j]) idx = j;
    end
  end
`else
  // Ascending scan: the highest set index is written last and wins.
  always_comb begin
    found = |cand;
    idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (cand[i]) idx = IDX_W'(i);
    end
  end
`endif

endmodule

// File: rtl/dec_req_encoder.sv
// Request encoder ahead of the priority decoder.
// Latches request pulses into a sticky pending vector, picks one unmasked
// pending request per transaction and presents it as X/Z/E_n with a
// valid/ready handshake. One grant per cycle while out_ready stays high.
// Optional macro DEC_REQ_ROUND_ROBIN_EN swaps fixed priority for rotation.
module dec_req_encoder
  import dec_pkg::*;
#(
  parameter logic [N_REQ-1:0] MASK_RST = 16'hFFFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             mask_we,
  input  logic [N_REQ-1:0] mask_wdata,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [IDX_W-1:0] dec_x,
  output logic [1:0]       dec_z,
  output logic             dec_e_n,
  output logic [N_REQ-1:0] pending
);

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_PRESENT = 1'b1;

  logic [0:0]       state;
  logic [N_REQ-1:0] mask;
  logic [N_REQ-1:0] clr;
  logic [N_REQ-1:0] cand;
  logic             accept;
  logic             found;
  logic [IDX_W-1:0] pick;

  assign out_valid = (state == S_PRESENT);
  assign dec_e_n   = ~out_valid;
  assign accept    = out_valid & out_ready;
  assign clr       = accept ? (N_REQ'(1) << dec_x) : '0;
  // The index being retired this edge must not be re-picked from stale state.
  assign cand      = pending & mask & ~clr;

`ifdef DEC_REQ_ROUND_ROBIN_EN
  logic [IDX_W-1:0] p;

  // Rotation pointer moves past each accepted index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      p <= '0;
    else if (accept) p <= dec_x + 1'b1;
  end

  dec_req_pick u_pick (
    .cand  (cand),
    .p     (p),
    .found (found),
    .idx   (pick)
  );
`else
  dec_req_pick u_pick (
    .cand  (cand),
    .found (found),
    .idx   (pick)
  );
`endif

  // Sticky pending vector; a fresh request beats the acceptance clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= (pending & ~clr) | req;
  end

  // Request-enable mask register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       mask <= MASK_RST;
    else if (mask_we) mask <= mask_wdata;
  end

  // Output slot FSM: load a pick when free or on acceptance, hold under stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      dec_x <= '0;
      dec_z <= MODE_2X4;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            state <= S_PRESENT;
            dec_x <= pick;
            dec_z <= idx_to_mode(pick);
          end
        end
        S_PRESENT: begin
          if (out_ready) begin
            if (found) begin
              dec_x <= pick;
              dec_z <= idx_to_mode(pick);
            end else begin
              state <= S_IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule
